modbus_frame_tx: RTL and testbench
==================================

Name: modbus_frame_tx

Overview:
Modbus RTU slave response transmitter, the transmit-side counterpart of the slave frame receiver. It latches the response fields and serialises the frame byte-by-byte to the UART transmitter. CRC-16 is computed on the fly and appended low byte first. After the last byte it enforces the 3.5-character silent interval before accepting the next frame.

Parameters:
T35_CYCLES, 16'd3646, clk cycles of 3.5-char gap after last byte (e.g. 9600 baud @ 1 MHz-equivalent; set per baud).
CNT_W, 16, width of gap counter; must hold T35_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
tx_start  in  1  one-cycle request; fields below sampled this cycle
dev_addr  in  8  slave address, byte 0 of frame
func_code  in  8  function code of the request being answered
addr  in  16  register address, echoed for non-0x03 responses
data  in  16  register value (0x03) or echoed write value
exc_vld  in  1  1 = send exception response
exc_code  in  8  exception code, used when exc_vld=1
uart_tx_done  in  1  one-cycle pulse: UART finished current byte
uart_tx_vld  out  1  one-cycle pulse: uart_tx_data valid, start byte
uart_tx_data  out  8  byte to transmit
tx_busy  out  1  high from accepted tx_start until gap expires
tx_frame_done  out  1  one-cycle pulse when last byte's uart_tx_done seen

Behaviour:
- Reset: all outputs 0, state IDLE, CRC reg 0xFFFF, byte index 0, gap counter 0. Async reset mid-frame aborts immediately; no partial completion.
- Frame formats, selected at tx_start and latched:
  - EXC (exc_vld=1): dev_addr, func_code|0x80, exc_code, CRC_lo, CRC_hi (5 bytes).
  - READ (func_code==0x03): dev_addr, 0x03, 0x02, data[15:8], data[7:0], CRC_lo, CRC_hi (7 bytes).
  - ECHO (otherwise): dev_addr, func_code, addr[15:8], addr[7:0], data[15:8], data[7:0], CRC_lo, CRC_hi (8 bytes).
- CRC: Modbus CRC-16, init 0xFFFF, reflected poly 0xA001, no final XOR. The payload byte's update is applied in the cycle that byte is issued (uart_tx_vld=1). CRC bytes are not folded into the CRC.
- FSM: IDLE -> LOAD -> SEND -> WAIT -> (SEND | GAP) -> IDLE.
  - IDLE: tx_busy=0. On tx_start latch fields, set CRC=0xFFFF, idx=0, go LOAD; tx_busy=1 next cycle.
  - LOAD: one cycle; selects byte idx from latched fields. Goes SEND.
  - SEND: uart_tx_vld=1 for exactly one cycle with uart_tx_data. Goes WAIT.
  - WAIT: hold uart_tx_data stable. On uart_tx_done: if idx==len-1, pulse tx_frame_done, clear gap counter, go GAP; else idx++ and go LOAD.
  - GAP: counter increments each cycle. When counter==T35_CYCLES-1, go IDLE.
- Latency: tx_start at cycle N gives the first uart_tx_vld at cycle N+2. uart_tx_done at cycle M gives the next uart_tx_vld at cycle M+2.
- tx_start while tx_busy=1: ignored; latched fields unchanged.
- uart_tx_done outside WAIT: ignored.
- tx_start in the same cycle GAP exits: ignored. It is accepted only when the state is IDLE.
- Input fields may change after tx_start without effect.

Decomposition:
- Package modbus_pkg: function codes (FC_READ_HOLD=8'h03, FC_WRITE_SINGLE=8'h06), EXC_FLAG=8'h80, CRC_INIT=16'hFFFF, CRC_POLY=16'hA001, frame-length constants (5/7/8), state enum, and pure function crc16_byte(crc, byte) doing the 8-iteration update. Share it with the receiver/CRC checker.
- No sub-module: the CRC is the package function and the FSM/mux is a single block.

Test Plan:
- ECHO, dev_addr=0x01, func=0x06, addr=0x0001, data=0x0003 -> bytes 01 06 00 01 00 03 98 0B. One tx_frame_done. tx_busy low exactly T35_CYCLES cycles after the done pulse.
- EXC, dev_addr=0x01, func=0x03, exc_code=0x02 -> bytes 01 83 02 C0 F1. Five uart_tx_vld pulses total.
- READ, dev_addr=0x11, func=0x03, data=0xABCD -> bytes 11 03 02 AB CD plus 2 CRC bytes matching the bench crc16 model, low byte first.
- tx_start pulsed again during byte 3 with different fields -> transmitted frame unchanged, no second frame after the gap. Also drive uart_tx_done with random 1-200 cycle delays -> byte order intact, one vld per done.
- rst_n asserted while in WAIT of byte 4 -> outputs 0 asynchronously. A new tx_start after release sends a full correct frame with CRC restarted from 0xFFFF.
- uart_tx_done pulsed in IDLE/GAP and tx_start in the GAP-exit cycle -> no state change, no uart_tx_vld. Latency check: tx_start at N gives uart_tx_vld at N+2.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants, FSM state type and CRC-16 byte update.
// Used by the slave response transmitter, the frame receiver and the CRC checker.
package modbus_pkg;

    localparam logic [7:0]  FC_READ_HOLD    = 8'h03;
    localparam logic [7:0]  FC_WRITE_SINGLE = 8'h06;
    localparam logic [7:0]  EXC_FLAG        = 8'h80;
    localparam logic [15:0] CRC_INIT        = 16'hFFFF;
    localparam logic [15:0] CRC_POLY        = 16'hA001;

    localparam logic [3:0]  LEN_EXC  = 4'd5;
    localparam logic [3:0]  LEN_READ = 4'd7;
    localparam logic [3:0]  LEN_ECHO = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        FMT_EXC,
        FMT_READ,
        FMT_ECHO
    } fmt_t;

    // Reflected CRC-16: fold one byte in LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_frame_tx_if.sv
// Request fields, UART byte handshake and status of the Modbus response transmitter.
interface modbus_frame_tx_if;
    logic        tx_start;
    logic [7:0]  dev_addr;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic        exc_vld;
    logic [7:0]  exc_code;
    logic        uart_tx_done;
    logic        uart_tx_vld;
    logic [7:0]  uart_tx_data;
    logic        tx_busy;
    logic        tx_frame_done;

    modport slave (
        input  tx_start, dev_addr, func_code, addr, data, exc_vld, exc_code, uart_tx_done,
        output uart_tx_vld, uart_tx_data, tx_busy, tx_frame_done
    );

    modport master (
        output tx_start, dev_addr, func_code, addr, data, exc_vld, exc_code, uart_tx_done,
        input  uart_tx_vld, uart_tx_data, tx_busy, tx_frame_done
    );
endinterface

// File: rtl/modbus_frame_tx.sv
// Modbus RTU slave response transmitter: latches the response, streams it byte by byte
// with an on-the-fly CRC appended low byte first, then holds off for the 3.5-char gap.
module modbus_frame_tx
    import modbus_pkg::*;
#(
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] T35_CYCLES = 16'd3646
) (
    input  logic              clk,
    input  logic              rst_n,
    modbus_frame_tx_if.slave  bus
);

    state_t           r_state, w_next;
    fmt_t             r_fmt;
    logic [7:0]       r_dev, r_fc, r_exc_code, r_byte;
    logic [15:0]      r_addr, r_data, r_crc;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_len;
    logic [7:0]       w_pay, w_byte;
    logic             w_last, w_is_payload;

    always_comb begin
        w_len = LEN_ECHO;
        w_pay = 8'h00;
        case (r_fmt)
            FMT_EXC: begin
                w_len = LEN_EXC;
                case (r_idx)
                    3'd0:    w_pay = r_dev;
                    3'd1:    w_pay = r_fc | EXC_FLAG;
                    default: w_pay = r_exc_code;
                endcase
            end
            FMT_READ: begin
                w_len = LEN_READ;
                case (r_idx)
                    3'd0:    w_pay = r_dev;
                    3'd1:    w_pay = FC_READ_HOLD;
                    3'd2:    w_pay = 8'h02;
                    3'd3:    w_pay = r_data[15:8];
                    default: w_pay = r_data[7:0];
                endcase
            end
            default: begin
                w_len = LEN_ECHO;
                case (r_idx)
                    3'd0:    w_pay = r_dev;
                    3'd1:    w_pay = r_fc;
                    3'd2:    w_pay = r_addr[15:8];
                    3'd3:    w_pay = r_addr[7:0];
                    3'd4:    w_pay = r_data[15:8];
                    default: w_pay = r_data[7:0];
                endcase
            end
        endcase
    end

    // The CRC register is final by the time the first CRC byte is loaded.
    assign w_last       = ({1'b0, r_idx} == (w_len - 4'd1));
    assign w_is_payload = ({1'b0, r_idx} <  (w_len - 4'd2));
    assign w_byte       = w_last                                 ? r_crc[15:8] :
                          ({1'b0, r_idx} == (w_len - 4'd2))      ? r_crc[7:0]  : w_pay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.tx_start) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: if (bus.uart_tx_done) w_next = w_last ? ST_GAP : ST_LOAD;
            ST_GAP:  if (r_cnt == T35_CYCLES - 1'b1) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.uart_tx_vld   = (r_state == ST_SEND);
        bus.uart_tx_data  = r_byte;
        bus.tx_busy       = (r_state != ST_IDLE);
        bus.tx_frame_done = (r_state == ST_WAIT) && bus.uart_tx_done && w_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fmt      <= FMT_EXC;
            r_dev      <= 8'h00;
            r_fc       <= 8'h00;
            r_exc_code <= 8'h00;
            r_addr     <= 16'h0000;
            r_data     <= 16'h0000;
            r_byte     <= 8'h00;
            r_crc      <= CRC_INIT;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.tx_start) begin
                    r_fmt      <= bus.exc_vld ? FMT_EXC :
                                  (bus.func_code == FC_READ_HOLD) ? FMT_READ : FMT_ECHO;
                    r_dev      <= bus.dev_addr;
                    r_fc       <= bus.func_code;
                    r_exc_code <= bus.exc_code;
                    r_addr     <= bus.addr;
                    r_data     <= bus.data;
                    r_crc      <= CRC_INIT;
                    r_idx      <= 3'd0;
                end
                ST_LOAD: r_byte <= w_byte;
                ST_SEND: if (w_is_payload) r_crc <= crc16_byte(r_crc, r_byte);
                ST_WAIT: if (bus.uart_tx_done) begin
                    if (w_last) r_cnt <= '0;
                    else        r_idx <= r_idx + 3'd1;
                end
                ST_GAP:  r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Randomised bench for modbus_frame_tx: frames are predicted from the Modbus RTU
// response formats with a plain CRC-16 model and compared byte by byte.
module tb_modbus_frame_tx;

    localparam int T35 = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modbus_frame_tx_if bus();

    modbus_frame_tx #(.CNT_W(16), .T35_CYCLES(16'(T35))) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] fr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] m[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (m[i]) begin
            c = c ^ {8'h00, m[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Expected response bytes straight from the frame layouts.
    task automatic build(input logic [7:0] dev, input logic [7:0] fc, input logic [15:0] a,
                         input logic [15:0] d, input bit exc, input logic [7:0] ec);
        logic [15:0] c;
        fr.delete();
        fr.push_back(dev);
        if (exc) begin
            fr.push_back(fc | 8'h80);
            fr.push_back(ec);
        end else if (fc == 8'h03) begin
            fr.push_back(8'h03);
            fr.push_back(8'h02);
            fr.push_back(d[15:8]);
            fr.push_back(d[7:0]);
        end else begin
            fr.push_back(fc);
            fr.push_back(a[15:8]);
            fr.push_back(a[7:0]);
            fr.push_back(d[15:8]);
            fr.push_back(d[7:0]);
        end
        c = crc_model(fr);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
    endtask

    task automatic scramble_fields();
        bus.dev_addr  = 8'($urandom);
        bus.func_code = 8'($urandom);
        bus.addr      = 16'($urandom);
        bus.data      = 16'($urandom);
        bus.exc_vld   = 1'($urandom);
        bus.exc_code  = 8'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.uart_tx_vld) begin
            cap_q.push_back(bus.uart_tx_data);
            if (exp_q.size() == 0) chk("unexpected_vld", 1, 0);
            else                   chk("byte", {24'h0, bus.uart_tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    // Called #1 after a rising edge with the DUT idle.
    task automatic send(input logic [7:0] dev, input logic [7:0] fc, input logic [15:0] a,
                        input logic [15:0] d, input bit exc, input logic [7:0] ec,
                        input int maxd, input int abort_b, input bit poke);
        int t, dly, len;
        bus.tx_start  = 1'b1;
        bus.dev_addr  = dev;
        bus.func_code = fc;
        bus.addr      = a;
        bus.data      = d;
        bus.exc_vld   = exc;
        bus.exc_code  = ec;
        build(dev, fc, a, d, exc, ec);
        foreach (fr[i]) exp_q.push_back(fr[i]);
        len = fr.size();
        cap_q.delete();
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        scramble_fields();
        chk("busy_after_start", bus.tx_busy, 1);
        chk("no_vld_n1", bus.uart_tx_vld, 0);
        for (int b = 0; b < len; b++) begin
            t = 0;
            while (!bus.uart_tx_vld && t < 400) begin
                @(posedge clk); #1;
                t++;
            end
            chk("latency", t, 1);
            if (!bus.uart_tx_vld) return;
            if (b == abort_b) begin
                rst_n = 1'b0;
                #1;
                chk("rst_vld", bus.uart_tx_vld, 0);
                chk("rst_data", {24'h0, bus.uart_tx_data}, 0);
                chk("rst_busy", bus.tx_busy, 0);
                chk("rst_fdone", bus.tx_frame_done, 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            dly = $urandom_range(maxd, 1);
            if (poke && b == 2 && dly < 3) dly = 3;
            for (int k = 1; k <= dly; k++) begin
                @(posedge clk); #1;
                bus.tx_start = 1'b0;
                chk("vld_once", bus.uart_tx_vld, 0);
                if (poke && b == 2 && k == 1) begin
                    scramble_fields();
                    bus.tx_start = 1'b1;
                end
            end
            bus.uart_tx_done = 1'b1;
            #1;
            chk("frame_done", bus.tx_frame_done, 32'(b == len - 1));
            @(posedge clk); #1;
            bus.uart_tx_done = 1'b0;
        end
        chk("vld_count", cap_q.size(), len);
        for (int k = 1; k <= T35; k++) begin
            chk("gap_busy", bus.tx_busy, 1);
            chk("gap_no_vld", bus.uart_tx_vld, 0);
            if (k == 3) bus.uart_tx_done = 1'b1;
            if (poke && k == T35) begin
                scramble_fields();
                bus.tx_start = 1'b1;
            end
            @(posedge clk); #1;
            bus.uart_tx_done = 1'b0;
            bus.tx_start = 1'b0;
        end
        chk("gap_end_idle", bus.tx_busy, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("post_idle_busy", bus.tx_busy, 0);
            chk("post_idle_vld", bus.uart_tx_vld, 0);
        end
        chk("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit1[8];
        logic [7:0] lit2[5];
        logic [7:0] lit3[5];
        logic [15:0] c3;
        logic [7:0] fc;
        lit1 = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        lit2 = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        lit3 = '{8'h11, 8'h03, 8'h02, 8'hAB, 8'hCD};

        bus.tx_start = 1'b0;
        bus.uart_tx_done = 1'b0;
        scramble_fields();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", bus.uart_tx_vld, 0);
        chk("reset_data", {24'h0, bus.uart_tx_data}, 0);
        chk("reset_busy", bus.tx_busy, 0);
        chk("reset_fdone", bus.tx_frame_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray done while idle must not start anything.
        bus.uart_tx_done = 1'b1;
        @(posedge clk); #1;
        bus.uart_tx_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("idle_done_vld", bus.uart_tx_vld, 0);
            chk("idle_done_busy", bus.tx_busy, 0);
            @(posedge clk); #1;
        end

        send(8'h01, 8'h06, 16'h0001, 16'h0003, 1'b0, 8'h00, 4, -1, 1'b0);
        for (int i = 0; i < 8; i++) chk("echo_literal", {24'h0, cap_q[i]}, {24'h0, lit1[i]});

        send(8'h01, 8'h03, 16'h1234, 16'h5678, 1'b1, 8'h02, 6, -1, 1'b0);
        chk("exc_len", cap_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("exc_literal", {24'h0, cap_q[i]}, {24'h0, lit2[i]});

        send(8'h11, 8'h03, 16'h0000, 16'hABCD, 1'b0, 8'h00, 200, -1, 1'b1);
        chk("read_len", cap_q.size(), 7);
        for (int i = 0; i < 5; i++) chk("read_literal", {24'h0, cap_q[i]}, {24'h0, lit3[i]});
        fr.delete();
        for (int i = 0; i < 5; i++) fr.push_back(lit3[i]);
        c3 = crc_model(fr);
        chk("read_crc_lo", {24'h0, cap_q[5]}, {24'h0, c3[7:0]});
        chk("read_crc_hi", {24'h0, cap_q[6]}, {24'h0, c3[15:8]});

        send(8'h22, 8'h10, 16'hBEEF, 16'hCAFE, 1'b0, 8'h00, 8, 3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_busy", bus.tx_busy, 0);
        send(8'h22, 8'h10, 16'hBEEF, 16'hCAFE, 1'b0, 8'h00, 8, -1, 1'b0);
        chk("restart_len", cap_q.size(), 8);

        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(2, 0))
                0:       fc = 8'h03;
                1:       fc = 8'h06;
                default: fc = 8'($urandom);
            endcase
            send(8'($urandom), fc, 16'($urandom), 16'($urandom),
                 ($urandom_range(3, 0) == 0), 8'($urandom), 20, -1, 1'(n % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
